// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: response owners and FSM states.
package mem_port_arbiter_pkg;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;
    localparam logic [1:0] OWN_LD   = 2'd3;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Data-over-fetch priority with a starvation guard: after STARVE_LIMIT consecutive
// data wins against a waiting fetch, the fetch wins the next arbitration.
module mem_port_arbiter_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic active_i,
    input  logic if_req_i,
    input  logic d_req_i,
    output logic grant_fetch_o,
    output logic grant_data_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             limit_hit;

    assign limit_hit     = (count_q == CNT_W'(STARVE_LIMIT));
    assign grant_fetch_o = active_i & if_req_i & (~d_req_i | limit_hit);
    assign grant_data_o  = active_i & d_req_i & ~grant_fetch_o;

    // The streak only counts while fetch is actually waiting.
    always_comb begin
        count_d = count_q;
        if (!active_i || !if_req_i || grant_fetch_o) begin
            count_d = '0;
        end else if (grant_data_o && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch, data and loader ports;
// registers one command per cycle and routes 1-cycle-latency read data to its owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          d_stall,
    input  logic          ld_mode,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_e    state_q, state_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]    cmd_own_q, cmd_own_d;
    logic [1:0]    resp_own_q;
    logic          core_active;
    logic          grant_if;
    logic          grant_d;

    // Core ports are only arbitrated in RUN and never in the cycle ld_mode is seen.
    assign core_active = (state_q == RUN) && !ld_mode;

    mem_port_arbiter_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk           (clk),
        .clr           (clr),
        .active_i      (core_active),
        .if_req_i      (if_req),
        .d_req_i       (d_req),
        .grant_fetch_o (grant_if),
        .grant_data_o  (grant_d)
    );

    always_comb begin
        state_d     = state_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cmd_own_d   = OWN_NONE;
        case (state_q)
            RUN: begin
                if (ld_mode) begin
                    state_d = (cmd_own_q != OWN_NONE) ? DRAIN : LOAD;
                end else if (grant_d) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    cmd_own_d   = d_we ? OWN_NONE : OWN_D;
                end else if (grant_if) begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = if_addr;
                    cmd_own_d  = OWN_IF;
                end
            end
            DRAIN: begin
                state_d = LOAD;
            end
            LOAD: begin
                if (!ld_mode) begin
                    state_d = RUN;
                end else if (ld_we) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ld_addr;
                    mem_wdata_d = ld_wdata;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // cmd_own tracks the read on mem_* now; resp_own the read whose data is on mem_rdata.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= RUN;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cmd_own_q   <= OWN_NONE;
            resp_own_q  <= OWN_NONE;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cmd_own_q   <= cmd_own_d;
            resp_own_q  <= cmd_own_q;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign if_valid = (resp_own_q == OWN_IF);
    assign d_valid  = (resp_own_q == OWN_D);
    assign if_rdata = if_valid ? mem_rdata : '0;
    assign d_rdata  = d_valid  ? mem_rdata : '0;

    assign if_stall = if_req & ~grant_if;
    assign d_stall  = d_req & ~grant_d;
    assign ld_busy  = (state_q == DRAIN);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed sequences, an arbitration
// vector table and a randomized run against a behavioural arbitration model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;
    localparam int NR = 300;

    logic          clk = 1'b0;
    logic          clr;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          if_stall;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          d_stall;
    logic          ld_mode;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_busy;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] memRdata;

    logic          preload;
    logic [DW-1:0] memArr [0:63];

    int testsRun  = 0;
    int failCount = 0;

    typedef struct packed {
        logic ifReq;
        logic dReq;
        logic expIfStall;
        logic expDStall;
        logic expIfValid;
        logic expDValid;
    } vec_t;

    vec_t          vecs [16];
    bit            expIfV [NR+4];
    bit            expDV  [NR+4];
    logic [DW-1:0] expIfD [NR+4];
    logic [DW-1:0] expDD  [NR+4];
    logic [DW-1:0] shadow [16];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW           (AW),
        .DW           (DW),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .if_stall  (if_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .d_stall   (d_stall),
        .ld_mode   (ld_mode),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_busy   (ld_busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (memRdata)
    );

    // Single-port synchronous memory macro with one cycle of read latency.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) memArr[i] <= 32'hA0 + 32'(i);
        end else if (mem_en) begin
            if (mem_we) memArr[mem_addr[5:0]] <= mem_wdata;
            else        memRdata <= memArr[mem_addr[5:0]];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ifReq, input logic [AW-1:0] ifAddr, input logic dReq,
                                 input logic dWe, input logic [AW-1:0] dAddr, input logic [DW-1:0] dWdata);
        if_req  = ifReq;
        if_addr = ifAddr;
        d_req   = dReq;
        d_we    = dWe;
        d_addr  = dAddr;
        d_wdata = dWdata;
    endtask

    task automatic loaderStim(input logic ldMode, input logic ldWe, input logic [AW-1:0] ldAddr, input logic [DW-1:0] ldWdata);
        ld_mode  = ldMode;
        ld_we    = ldWe;
        ld_addr  = ldAddr;
        ld_wdata = ldWdata;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clr     = 1'b1;
        preload = 1'b1;
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 0, 0);
        loaderStim(1'b0, 1'b0, 0, 0);
        repeat (2) @(posedge clk);
        #1 preload = 1'b0;

        // Reset state.
        @(negedge clk);
        checkBit("rst mem_en", mem_en, 1'b0);
        checkBit("rst mem_we", mem_we, 1'b0);
        checkOutput("rst mem_addr", mem_addr, 32'h0);
        checkOutput("rst mem_wdata", mem_wdata, 32'h0);
        checkBit("rst if_valid", if_valid, 1'b0);
        checkBit("rst d_valid", d_valid, 1'b0);
        checkOutput("rst if_rdata", if_rdata, 32'h0);
        checkOutput("rst d_rdata", d_rdata, 32'h0);
        checkBit("rst if_stall", if_stall, 1'b0);
        checkBit("rst d_stall", d_stall, 1'b0);
        checkBit("rst ld_busy", ld_busy, 1'b0);
        nextCycle();
        clr = 1'b0;
        nextCycle();

        // Fetch-only stream, addresses 0..2.
        for (int c = 0; c < 6; c++) begin
            applyStimulus(c < 3, 32'(c), 1'b0, 1'b0, 0, 0);
            @(negedge clk);
            if (c < 3) checkBit("fetch if_stall", if_stall, 1'b0);
            checkBit("fetch if_valid", if_valid, (c >= 2) && (c < 5));
            if ((c >= 2) && (c < 5)) checkOutput("fetch if_rdata", if_rdata, 32'hA0 + 32'(c - 2));
            nextCycle();
        end

        // Store then load the same address.
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, 0, c < 2, c == 0, 5, 32'h1234);
            @(negedge clk);
            if (c < 2) checkBit("stld d_stall", d_stall, 1'b0);
            checkBit("stld d_valid", d_valid, c == 3);
            if (c == 3) checkOutput("stld d_rdata", d_rdata, 32'h1234);
            nextCycle();
        end

        // Contention table: {ifReq, dReq, expIfStall, expDStall, expIfValid, expDValid}.
        vecs[0]  = 6'b111000;  vecs[1]  = 6'b111000;
        vecs[2]  = 6'b111001;  vecs[3]  = 6'b111001;
        vecs[4]  = 6'b110101;  vecs[5]  = 6'b111001;
        vecs[6]  = 6'b111010;  vecs[7]  = 6'b111001;
        vecs[8]  = 6'b111001;  vecs[9]  = 6'b110101;
        vecs[10] = 6'b010001;  vecs[11] = 6'b100010;
        vecs[12] = 6'b111001;  vecs[13] = 6'b000010;
        vecs[14] = 6'b000001;  vecs[15] = 6'b000000;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].ifReq, 20, vecs[i].dReq, 1'b0, 21, 0);
            @(negedge clk);
            checkBit($sformatf("tbl[%0d] if_stall", i), if_stall, vecs[i].expIfStall);
            checkBit($sformatf("tbl[%0d] d_stall", i), d_stall, vecs[i].expDStall);
            checkBit($sformatf("tbl[%0d] if_valid", i), if_valid, vecs[i].expIfValid);
            checkBit($sformatf("tbl[%0d] d_valid", i), d_valid, vecs[i].expDValid);
            if (vecs[i].expIfValid) checkOutput($sformatf("tbl[%0d] if_rdata", i), if_rdata, 32'hB4);
            if (vecs[i].expDValid)  checkOutput($sformatf("tbl[%0d] d_rdata", i), d_rdata, 32'hB5);
            nextCycle();
        end

        // Loader entry with a data read in flight, loader writes, then return to RUN.
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 22, 0);
        @(negedge clk);
        checkBit("ld grant d_stall", d_stall, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 7, 1'b0, 1'b0, 0, 0);
        loaderStim(1'b1, 1'b0, 0, 0);
        @(negedge clk);
        checkBit("ld c1 ld_busy", ld_busy, 1'b0);
        checkBit("ld c1 if_stall", if_stall, 1'b1);
        checkBit("ld c1 d_valid", d_valid, 1'b0);
        nextCycle();
        @(negedge clk);
        checkBit("ld drain ld_busy", ld_busy, 1'b1);
        checkBit("ld drain d_valid", d_valid, 1'b1);
        checkOutput("ld drain d_rdata", d_rdata, 32'hB6);
        checkBit("ld drain if_stall", if_stall, 1'b1);
        checkBit("ld drain mem_en", mem_en, 1'b0);
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            loaderStim(1'b1, 1'b1, 32'(i), 32'h10 + 32'(i));
            @(negedge clk);
            checkBit("ld write ld_busy", ld_busy, 1'b0);
            checkBit("ld write if_stall", if_stall, 1'b1);
            checkBit("ld write if_valid", if_valid, 1'b0);
            if (i > 0) begin
                checkBit("ld write mem_we", mem_we, 1'b1);
                checkOutput("ld write mem_addr", mem_addr, 32'(i - 1));
                checkOutput("ld write mem_wdata", mem_wdata, 32'h10 + 32'(i - 1));
            end
            nextCycle();
        end
        loaderStim(1'b0, 1'b0, 0, 0);
        @(negedge clk);
        checkBit("ld exit if_stall", if_stall, 1'b1);
        checkBit("ld exit mem_en", mem_en, 1'b1);
        checkOutput("ld exit mem_addr", mem_addr, 32'h3);
        nextCycle();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(c == 0, 2, 1'b0, 1'b0, 0, 0);
            @(negedge clk);
            if (c == 0) checkBit("post-ld if_stall", if_stall, 1'b0);
            checkBit("post-ld if_valid", if_valid, c == 2);
            if (c == 2) checkOutput("post-ld if_rdata", if_rdata, 32'h12);
            nextCycle();
        end

        // Asynchronous reset between a fetch grant and its response.
        applyStimulus(1'b1, 23, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        checkBit("arst grant if_stall", if_stall, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        checkBit("arst cmd mem_en", mem_en, 1'b1);
        checkOutput("arst cmd mem_addr", mem_addr, 32'd23);
        #1 clr = 1'b1;
        #1;
        checkBit("arst mem_en", mem_en, 1'b0);
        checkOutput("arst mem_addr", mem_addr, 32'h0);
        checkBit("arst if_valid", if_valid, 1'b0);
        checkOutput("arst if_rdata", if_rdata, 32'h0);
        nextCycle();
        clr = 1'b0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(c == 2, 24, 1'b0, 1'b0, 0, 0);
            @(negedge clk);
            if (c == 2) checkBit("arst refetch if_stall", if_stall, 1'b0);
            checkBit("arst post if_valid", if_valid, c == 4);
            if (c == 4) checkOutput("arst refetch if_rdata", if_rdata, 32'hB8);
            nextCycle();
        end

        // Randomized traffic on addresses 16..31 against a behavioural model.
        for (int i = 0; i < 16; i++) shadow[i] = 32'hB0 + 32'(i);
        for (int k = 0; k < NR + 4; k++) begin
            expIfV[k] = 1'b0;
            expDV[k]  = 1'b0;
            expIfD[k] = '0;
            expDD[k]  = '0;
        end
        begin
            int streak;
            streak = 0;
            for (int k = 0; k < NR + 2; k++) begin
                logic          ir, dr, dw, fetchWins, dataWins;
                logic [AW-1:0] ia, da;
                logic [DW-1:0] wd;
                ir = 1'b0; dr = 1'b0; dw = 1'b0; ia = 16; da = 16; wd = '0;
                if (k < NR) begin
                    ir = 1'($urandom_range(0, 1));
                    dr = 1'($urandom_range(0, 1));
                    dw = ($urandom_range(0, 3) == 0);
                    ia = 32'($urandom_range(31, 16));
                    da = 32'($urandom_range(31, 16));
                    wd = $urandom;
                end
                applyStimulus(ir, ia, dr, dw, da, wd);
                fetchWins = ir && (!dr || (streak == SL));
                dataWins  = dr && !fetchWins;
                if (fetchWins) begin
                    expIfV[k+2] = 1'b1;
                    expIfD[k+2] = shadow[ia - 16];
                end
                if (dataWins) begin
                    if (dw) begin
                        shadow[da - 16] = wd;
                    end else begin
                        expDV[k+2] = 1'b1;
                        expDD[k+2] = shadow[da - 16];
                    end
                end
                if (!ir || fetchWins) streak = 0;
                else if (dataWins)    streak = streak + 1;
                @(negedge clk);
                checkBit($sformatf("rnd[%0d] if_stall", k), if_stall, ir && !fetchWins);
                checkBit($sformatf("rnd[%0d] d_stall", k), d_stall, dr && !dataWins);
                checkBit($sformatf("rnd[%0d] if_valid", k), if_valid, expIfV[k]);
                checkBit($sformatf("rnd[%0d] d_valid", k), d_valid, expDV[k]);
                if (expIfV[k]) checkOutput($sformatf("rnd[%0d] if_rdata", k), if_rdata, expIfD[k]);
                if (expDV[k])  checkOutput($sformatf("rnd[%0d] d_rdata", k), d_rdata, expDD[k]);
                nextCycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
